omsp_atom_violation_ctrl: RTL and testbench
===========================================

// Module: omsp_atom_violation_ctrl
// PURPOSE
// - Downstream consumer of the atomicity monitor's atom_violation/gie outputs.
// - Latches the violation cause and the offending SM ID, defers to the next instruction boundary,
//   then raises a non-maskable violation IRQ toward the frontend.
// - Escalates to a PUC request on a missing ack or a nested violation.
// - Keeps a saturating violation counter for debug/status.
// PARAMETERS
// - CNT_WIDTH           8   width of viol_count (saturating)
// - ACK_TIMEOUT         64  cycles viol_irq may stay high unacked before escalation (>=2)
// - ESCALATE_ON_NESTED  1   1: violation while handling -> ESCALATE; 0: re-capture and restart
// PORTS
// - mclk            in   1          system clock
// - puc_rst         in   1          reset, synchronous, active-high
// - atom_violation  in   1          violation pulse from atomicity monitor
// - inst_clix       in   1          clix executing (cause classification)
// - enter_sm        in   1          SM entry this cycle (cause classification)
// - sm_id           in   16         ID of currently executing SM (0 = unprotected)
// - inst_boundary   in   1          last cycle of current instruction
// - irq_ack         in   1          frontend accepted viol_irq
// - viol_irq        out  1          non-maskable violation interrupt request (ignores gie)
// - viol_reset      out  1          PUC request; held until puc_rst
// - viol_cause      out  2          01 clix nest/bound, 10 SM entry nest, 11 both, 00 none
// - viol_sm_id      out  16         sm_id captured at violation
// - viol_count      out  CNT_WIDTH  total violations since reset, saturating
// - busy            out  1          state != IDLE
// BEHAVIOUR
// - Reset (puc_rst sampled high at posedge mclk): state=IDLE, timer=0, all outputs 0.
//   Reset overrides every other event, including mid-WAIT_BND/NOTIFY/ESCALATE.
// - Capture (on every accepted violation):
//   - viol_cause<={enter_sm,inst_clix}; if both are 0, use 01.
//   - viol_sm_id<=sm_id.
//   - viol_count<=viol_count+1, holding at 2^CNT_WIDTH-1.
// - IDLE:
//   - atom_violation -> capture, go to WAIT_BND.
//   - inst_boundary is not sampled in IDLE.
// - WAIT_BND:
//   - inst_boundary -> NOTIFY, timer<=0.
//   - atom_violation -> count++ only; if ESCALATE_ON_NESTED go to ESCALATE, else re-capture and stay.
//   - Violation has priority over boundary.
// - NOTIFY:
//   - viol_irq=1 (combinational from state).
//   - irq_ack -> IDLE; viol_irq low on the next cycle.
//   - irq_ack together with atom_violation -> capture, go to WAIT_BND (new violation, no escalation).
//   - atom_violation without ack -> count++; go to ESCALATE (or re-capture -> WAIT_BND if ESCALATE_ON_NESTED=0).
//   - No ack and timer==ACK_TIMEOUT-1 -> ESCALATE; otherwise timer++.
//   - timer width is $clog2(ACK_TIMEOUT)+1.
// - ESCALATE:
//   - viol_reset=1 and viol_irq=0; remain here until puc_rst.
//   - Further violations only increment the count.
// - Latency:
//   - violation at edge N -> cause/id/count valid after N.
//   - inst_boundary seen at N+1 -> viol_irq high from N+2.
// - viol_cause/viol_sm_id hold their last captured value after returning to IDLE.
// - busy=1 in WAIT_BND, NOTIFY and ESCALATE.
// TESTING
// - Basic handshake: sm_id=5, inst_clix=1, pulse violation; boundary 3 cycles later; ack after 4
//   -> cause=01, id=5, count=1, irq high for exactly 4 cycles, then IDLE.
// - Timeout: violation, boundary, never ack -> viol_irq high for 64 cycles;
//   viol_reset rises on the next cycle and stays high until puc_rst; then all outputs are 0.
// - Nested violation: enter_sm=1 violation, then a second violation in WAIT_BND
//   -> count=2, ESCALATE; with ESCALATE_ON_NESTED=0 -> cause re-captured, irq follows.
// - Ack coincident with a new violation (inst_clix=1,enter_sm=1)
//   -> cause=11, WAIT_BND, no viol_reset.
// - Saturation: CNT_WIDTH=2, 5 handled violations -> count sequence 1,2,3,3,3.
// - Reset mid-NOTIFY (cycle 2 of irq) -> next cycle state IDLE, viol_irq=0, count=0.

Source files
------------

// File: rtl/omsp_atom_violation_ctrl.sv
// Atomicity-violation handler: captures cause/SM ID, waits for an instruction boundary,
// raises a non-maskable IRQ, and escalates to a PUC request on timeout or nesting.
module omsp_atom_violation_ctrl #(
  parameter int CNT_WIDTH          = 8,
  parameter int ACK_TIMEOUT        = 64,
  parameter bit ESCALATE_ON_NESTED = 1'b1
) (
  input  logic                 mclk,
  input  logic                 puc_rst,
  input  logic                 atom_violation,
  input  logic                 inst_clix,
  input  logic                 enter_sm,
  input  logic [15:0]          sm_id,
  input  logic                 inst_boundary,
  input  logic                 irq_ack,
  output logic                 viol_irq,
  output logic                 viol_reset,
  output logic [1:0]           viol_cause,
  output logic [15:0]          viol_sm_id,
  output logic [CNT_WIDTH-1:0] viol_count,
  output logic                 busy
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TW-1:0]        TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BND, S_NOTIFY, S_ESCALATE} state_t;

  state_t         r_state;
  logic [TW-1:0]  r_timer;

  logic [1:0]           w_cause;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_capture;

  // An unclassified violation is reported as a clix fault.
  assign w_cause   = (enter_sm | inst_clix) ? {enter_sm, inst_clix} : 2'b01;
  assign w_cnt_inc = (viol_count == CNT_MAX) ? viol_count : viol_count + 1'b1;

  // Cause/ID are refreshed only when the violation starts a new handling sequence.
  assign w_capture = atom_violation &
                     ((r_state == S_IDLE) ||
                      (r_state == S_NOTIFY && irq_ack) ||
                      (!ESCALATE_ON_NESTED && (r_state == S_WAIT_BND || r_state == S_NOTIFY)));

  assign viol_irq   = (r_state == S_NOTIFY);
  assign viol_reset = (r_state == S_ESCALATE);
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      viol_cause <= 2'b00;
      viol_sm_id <= 16'h0000;
      viol_count <= '0;
    end else begin
      if (atom_violation) viol_count <= w_cnt_inc;
      if (w_capture) begin
        viol_cause <= w_cause;
        viol_sm_id <= sm_id;
      end
      case (r_state)
        S_IDLE: begin
          if (atom_violation) r_state <= S_WAIT_BND;
        end
        S_WAIT_BND: begin
          if (atom_violation) begin
            if (ESCALATE_ON_NESTED) r_state <= S_ESCALATE;
          end else if (inst_boundary) begin
            r_state <= S_NOTIFY;
            r_timer <= '0;
          end
        end
        S_NOTIFY: begin
          if (irq_ack) begin
            r_state <= atom_violation ? S_WAIT_BND : S_IDLE;
          end else if (atom_violation) begin
            r_state <= ESCALATE_ON_NESTED ? S_ESCALATE : S_WAIT_BND;
          end else if (r_timer == TMO_LAST) begin
            r_state <= S_ESCALATE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_ESCALATE: r_state <= S_ESCALATE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_omsp_atom_violation_ctrl.sv
// Bench for omsp_atom_violation_ctrl: default, non-escalating-nest and 2-bit-counter variants
// share one stimulus stream; captured cause/ID/count is scoreboarded per violation.
module tb_omsp_atom_violation_ctrl;

  logic        mclk = 1'b0;
  logic        puc_rst, atom_violation, inst_clix, enter_sm, inst_boundary, irq_ack;
  logic [15:0] sm_id;

  logic        d_irq, d_reset, d_busy;
  logic [1:0]  d_cause;
  logic [15:0] d_id;
  logic [7:0]  d_count;

  logic        n_irq, n_reset, n_busy;
  logic [1:0]  n_cause;
  logic [15:0] n_id;
  logic [7:0]  n_count;

  logic        s_irq, s_reset, s_busy;
  logic [1:0]  s_cause;
  logic [15:0] s_id;
  logic [1:0]  s_count;

  typedef struct packed {
    logic [1:0]  cause;
    logic [15:0] id;
    logic [7:0]  count;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   errs   = 0;
  int   checks = 0;

  always #5 mclk = ~mclk;

  omsp_atom_violation_ctrl u_dut (
    .mclk(mclk), .puc_rst(puc_rst), .atom_violation(atom_violation), .inst_clix(inst_clix),
    .enter_sm(enter_sm), .sm_id(sm_id), .inst_boundary(inst_boundary), .irq_ack(irq_ack),
    .viol_irq(d_irq), .viol_reset(d_reset), .viol_cause(d_cause), .viol_sm_id(d_id),
    .viol_count(d_count), .busy(d_busy));

  omsp_atom_violation_ctrl #(.ESCALATE_ON_NESTED(1'b0)) u_nest0 (
    .mclk(mclk), .puc_rst(puc_rst), .atom_violation(atom_violation), .inst_clix(inst_clix),
    .enter_sm(enter_sm), .sm_id(sm_id), .inst_boundary(inst_boundary), .irq_ack(irq_ack),
    .viol_irq(n_irq), .viol_reset(n_reset), .viol_cause(n_cause), .viol_sm_id(n_id),
    .viol_count(n_count), .busy(n_busy));

  omsp_atom_violation_ctrl #(.CNT_WIDTH(2)) u_sat (
    .mclk(mclk), .puc_rst(puc_rst), .atom_violation(atom_violation), .inst_clix(inst_clix),
    .enter_sm(enter_sm), .sm_id(sm_id), .inst_boundary(inst_boundary), .irq_ack(irq_ack),
    .viol_irq(s_irq), .viol_reset(s_reset), .viol_cause(s_cause), .viol_sm_id(s_id),
    .viol_count(s_count), .busy(s_busy));

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic do_reset();
    puc_rst = 1'b1; atom_violation = 1'b0; inst_clix = 1'b0; enter_sm = 1'b0;
    sm_id = 16'h0; inst_boundary = 1'b0; irq_ack = 1'b0;
    tick();
    puc_rst = 1'b0;
  endtask

  task automatic fire(input logic clix, input logic ent, input logic [15:0] id);
    atom_violation = 1'b1; inst_clix = clix; enter_sm = ent; sm_id = id;
    tick();
    atom_violation = 1'b0; inst_clix = 1'b0; enter_sm = 1'b0;
  endtask

  task automatic boundary();
    inst_boundary = 1'b1;
    tick();
    inst_boundary = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({d_irq, d_reset, d_busy, d_cause, d_id, d_count} !== 29'h0) begin
      errs++; $display("FAIL reset_outputs got=%h want=0", {d_irq, d_reset, d_busy, d_cause, d_id, d_count});
    end
    checks++;
    if ({s_irq, s_reset, s_busy, s_count} !== 5'h0) begin
      errs++; $display("FAIL reset_sat got=%h want=0", {s_irq, s_reset, s_busy, s_count});
    end
  endtask

  task automatic test_basic();
    int hi;
    do_reset();
    exp_q.push_back('{cause: 2'b01, id: 16'd5, count: 8'd1});
    fire(1'b1, 1'b0, 16'd5);
    e = exp_q.pop_front();
    checks++;
    if ({d_cause, d_id, d_count} !== e) begin
      errs++; $display("FAIL basic_capture got=%h want=%h", {d_cause, d_id, d_count}, e);
    end
    tick(); tick();
    checks++;
    if ({d_busy, d_irq} !== 2'b10) begin
      errs++; $display("FAIL basic_wait busy/irq got=%b want=10", {d_busy, d_irq});
    end
    boundary();
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (d_irq === 1'b1) hi++;
      if (i == 3) irq_ack = 1'b1;
      tick();
    end
    irq_ack = 1'b0;
    checks++;
    if (hi !== 4) begin
      errs++; $display("FAIL basic_irq_cycles got=%0d want=4", hi);
    end
    checks++;
    if ({d_irq, d_busy, d_reset, d_cause, d_id} !== {3'b000, 2'b01, 16'd5}) begin
      errs++; $display("FAIL basic_idle got=%h want=%h", {d_irq, d_busy, d_reset, d_cause, d_id},
                       {3'b000, 2'b01, 16'd5});
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    fire(1'b1, 1'b0, 16'd3);
    boundary();
    n = 0;
    while (d_irq === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 64) begin
      errs++; $display("FAIL timeout_irq_cycles got=%0d want=64", n);
    end
    checks++;
    if ({d_reset, d_irq, d_busy} !== 3'b101) begin
      errs++; $display("FAIL timeout_escalate got=%b want=101", {d_reset, d_irq, d_busy});
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (d_reset !== 1'b1) begin
      errs++; $display("FAIL timeout_hold got=%b want=1", d_reset);
    end
    do_reset();
    checks++;
    if ({d_irq, d_reset, d_busy, d_cause, d_id, d_count} !== 29'h0) begin
      errs++; $display("FAIL timeout_puc got=%h want=0", {d_irq, d_reset, d_busy, d_cause, d_id, d_count});
    end
  endtask

  task automatic test_nested();
    do_reset();
    exp_q.push_back('{cause: 2'b10, id: 16'd7, count: 8'd1});
    fire(1'b0, 1'b1, 16'd7);
    e = exp_q.pop_front();
    checks++;
    if ({d_cause, d_id, d_count} !== e) begin
      errs++; $display("FAIL nested_first got=%h want=%h", {d_cause, d_id, d_count}, e);
    end
    fire(1'b1, 1'b0, 16'd9);
    checks++;
    if ({d_reset, d_irq, d_cause, d_id, d_count} !== {2'b10, 2'b10, 16'd7, 8'd2}) begin
      errs++; $display("FAIL nested_escalate got=%h want=%h", {d_reset, d_irq, d_cause, d_id, d_count},
                       {2'b10, 2'b10, 16'd7, 8'd2});
    end
    checks++;
    if ({n_reset, n_busy, n_cause, n_id, n_count} !== {2'b01, 2'b01, 16'd9, 8'd2}) begin
      errs++; $display("FAIL nested0_recapture got=%h want=%h", {n_reset, n_busy, n_cause, n_id, n_count},
                       {2'b01, 2'b01, 16'd9, 8'd2});
    end
    boundary();
    checks++;
    if ({n_irq, d_irq} !== 2'b10) begin
      errs++; $display("FAIL nested0_irq got=%b want=10", {n_irq, d_irq});
    end
    fire(1'b0, 1'b0, 16'd1);
    checks++;
    if ({d_reset, d_count, d_cause} !== {1'b1, 8'd3, 2'b10}) begin
      errs++; $display("FAIL escalate_count got=%h want=%h", {d_reset, d_count, d_cause}, {1'b1, 8'd3, 2'b10});
    end
  endtask

  task automatic test_ack_with_violation();
    do_reset();
    fire(1'b1, 1'b0, 16'd4);
    boundary();
    checks++;
    if (d_irq !== 1'b1) begin
      errs++; $display("FAIL ackviol_notify got=%b want=1", d_irq);
    end
    irq_ack = 1'b1;
    exp_q.push_back('{cause: 2'b11, id: 16'h0022, count: 8'd2});
    fire(1'b1, 1'b1, 16'h0022);
    irq_ack = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if ({d_cause, d_id, d_count} !== e) begin
      errs++; $display("FAIL ackviol_capture got=%h want=%h", {d_cause, d_id, d_count}, e);
    end
    tick();
    checks++;
    if ({d_busy, d_irq, d_reset} !== 3'b100) begin
      errs++; $display("FAIL ackviol_state got=%b want=100", {d_busy, d_irq, d_reset});
    end
  endtask

  task automatic test_saturation();
    logic [1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fire(1'b1, 1'b0, 16'(i));
      checks++;
      if (s_count !== seq[i]) begin
        errs++; $display("FAIL sat_count[%0d] got=%0d want=%0d", i, s_count, seq[i]);
      end
      boundary();
      checks++;
      if (s_irq !== 1'b1) begin
        errs++; $display("FAIL sat_irq[%0d] got=%b want=1", i, s_irq);
      end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
    end
    checks++;
    if ({s_busy, s_reset} !== 2'b00) begin
      errs++; $display("FAIL sat_idle got=%b want=00", {s_busy, s_reset});
    end
  endtask

  task automatic test_reset_mid_notify();
    do_reset();
    fire(1'b1, 1'b0, 16'd8);
    boundary();
    tick();
    checks++;
    if (d_irq !== 1'b1) begin
      errs++; $display("FAIL midreset_irq_cycle2 got=%b want=1", d_irq);
    end
    puc_rst = 1'b1;
    tick();
    puc_rst = 1'b0;
    checks++;
    if ({d_irq, d_busy, d_reset, d_count} !== 11'h0) begin
      errs++; $display("FAIL midreset_state got=%h want=0", {d_irq, d_busy, d_reset, d_count});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_nested();
    test_ack_with_violation();
    test_saturation();
    test_reset_mid_notify();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
